// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, round constants, GF(2^8) doubling, state/word types.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    // Forward S-box; SBOX[x] is the substitution of byte x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants, indexed by round number 1..10.
    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by 2 modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_128_cipher_if.sv
// Data bundle of the AES-128 cipher: plaintext/key in, ciphertext/round-10 key out.
// Latency: set by the core's LATENCY parameter.
// Backpressure: none; the bundle carries no handshake.
interface aes_128_cipher_if;
    import aes_pkg::*;

    state_t dat_in;   // plaintext, byte 0 in bits [127:120], column-major
    state_t key;      // cipher key, same byte order
    state_t dat_out;  // ciphertext
    state_t inv_key;  // round-10 key aligned with dat_out

    modport master (output dat_in, key, input dat_out, inv_key);
    modport slave  (input dat_in, key, output dat_out, inv_key);
endinterface

// File: rtl/aes_round_128.sv
// One AES-128 round plus key evolution: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Latency: 0 cycles when REG_OUT=0, 1 cycle when REG_OUT=1 (sync active-low clr zeroes both registers).
// Backpressure: none; a new state/key pair is accepted every cycle.
// Ports: dat_in/key_in = state and previous round key; rconst = this round's rcon;
//        skip_mix_col bypasses MixColumns (final round); dat_out/key_out = new state and round key.
module aes_round_128
    import aes_pkg::*;
#(
    parameter bit REG_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  state_t     dat_in,
    input  state_t     key_in,
    input  logic [7:0] rconst,
    input  logic       skip_mix_col,
    output state_t     dat_out,
    output state_t     key_out
);
    // Byte views: element i is FIPS byte i (bits [127-8i -: 8]).
    logic [0:15][7:0] din, sb, sr, mc, rk, dout;
    logic [0:3][31:0] kw, nk;
    word_t            tw;
    state_t           dat_nxt, key_nxt;

    always_comb begin
        din  = dat_in;
        kw   = key_in;
        sb   = '0;
        sr   = '0;
        mc   = '0;
        dout = '0;
        nk   = '0;

        // Key expansion step: RotWord + SubWord + rcon on the last word, then cascade.
        tw = {SBOX[kw[3][23:16]], SBOX[kw[3][15:8]], SBOX[kw[3][7:0]], SBOX[kw[3][31:24]]}
             ^ {rconst, 24'h000000};
        nk[0] = kw[0] ^ tw;
        for (int i = 1; i < 4; i++) begin
            nk[i] = kw[i] ^ nk[i-1];
        end
        rk = nk;

        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[din[i]];
        end

        // Row r rotates left by r columns; byte index = 4*col + row.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end

        // Circulant 02 03 01 01 per column; 03*x computed as xtime(x) ^ x.
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end

        for (int i = 0; i < 16; i++) begin
            dout[i] = (skip_mix_col ? sr[i] : mc[i]) ^ rk[i];
        end

        dat_nxt = dout;
        key_nxt = nk;
    end

    if (REG_OUT) begin : g_reg
        state_t dat_q, key_q;

        always_ff @(posedge clk) begin
            if (!clr) begin
                dat_q <= '0;
                key_q <= '0;
            end else begin
                dat_q <= dat_nxt;
                key_q <= key_nxt;
            end
        end

        assign dat_out = dat_q;
        assign key_out = key_q;
    end else begin : g_comb
        logic unused_clk_clr;
        assign unused_clk_clr = &{1'b0, clk, clr};
        assign dat_out = dat_nxt;
        assign key_out = key_nxt;
    end
endmodule

// File: rtl/aes_128_cipher.sv
// AES-128 encryption core: initial key XOR, ten chained rounds with on-the-fly key expansion.
// Latency: LATENCY=0 combinational, LATENCY=10 one register per round (sync active-low clr).
// Backpressure: none; one block per cycle, no valid or stall.
// Ports: clk, clr (ignored when LATENCY=0); bus carries dat_in/key in and dat_out/inv_key out.
module aes_128_cipher
    import aes_pkg::*;
#(
    parameter int LATENCY = 10
) (
    input  logic             clk,
    input  logic             clr,
    aes_128_cipher_if.slave  bus
);
    if (LATENCY != 0 && LATENCY != 10) begin : g_bad_latency
        $error("aes_128_cipher: LATENCY must be 0 or 10");
    end

    // st[r]/rk[r] are the state and round key after round r; index 0 is the input side.
    state_t st [0:10];
    state_t rk [0:10];

    assign rk[0] = bus.key;
    assign st[0] = bus.dat_in ^ bus.key;

    for (genvar r = 1; r <= 10; r++) begin : g_round
        aes_round_128 #(
            .REG_OUT (LATENCY == 10)
        ) u_round (
            .clk          (clk),
            .clr          (clr),
            .dat_in       (st[r-1]),
            .key_in       (rk[r-1]),
            .rconst       (RCON[r]),
            .skip_mix_col (r == 10),
            .dat_out      (st[r]),
            .key_out      (rk[r])
        );
    end

    // The round-10 key is where the decipher key schedule starts.
    assign bus.dat_out = st[10];
    assign bus.inv_key = rk[10];
endmodule

// File: tb/tb_aes_128_cipher.sv
module tb_aes_128_cipher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;
    int   total = 0;
    int   bad   = 0;

    aes_128_cipher_if bus_c ();
    aes_128_cipher_if bus_p ();

    aes_128_cipher #(.LATENCY(0)) u_comb (
        .clk (clk),
        .clr (clr),
        .bus (bus_c.slave)
    );

    aes_128_cipher #(.LATENCY(10)) u_pipe (
        .clk (clk),
        .clr (clr),
        .bus (bus_p.slave)
    );

    logic [127:0] rnd_dat_in, rnd_key_in, rnd_dat_out, rnd_key_out;
    logic [7:0]   rnd_rc;
    logic         rnd_skip;

    aes_round_128 #(.REG_OUT(1'b0)) u_round (
        .clk          (clk),
        .clr          (clr),
        .dat_in       (rnd_dat_in),
        .key_in       (rnd_key_in),
        .rconst       (rnd_rc),
        .skip_mix_col (rnd_skip),
        .dat_out      (rnd_dat_out),
        .key_out      (rnd_key_out)
    );

    // Known-answer vectors: FIPS-197 App. B, App. C.1, all-zero, two zero-key GFSbox cases.
    localparam logic [127:0] VEC_PT [5] = '{
        128'h3243f6a8885a308d313198a2e0370734, 128'h00112233445566778899aabbccddeeff,
        128'h00000000000000000000000000000000, 128'hf34481ec3cc627bacd5dc3fb08f273e6,
        128'h9798c4640bad75c7c3227db910174e72};
    localparam logic [127:0] VEC_KEY [5] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h000102030405060708090a0b0c0d0e0f,
        128'h0, 128'h0, 128'h0};
    localparam logic [127:0] VEC_CT [5] = '{
        128'h3925841d02dc09fbdc118597196a0b32, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0336763e966d92595a567cc9ce537f5e,
        128'ha9a1631bf4996954ebc093957b234589};
    localparam logic [127:0] VEC_K10 [5] = '{
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h13111d7fe3944a17f307a78b4d2b30c5,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    // ---------------- reference model (S-box from GF inverse + affine map) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        // x^254 by square-and-multiply; exponent bits 11111110.
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic model_enc(input logic [127:0] pt, input logic [127:0] k,
                             output logic [127:0] ct, output logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        logic [7:0]  s [4][4];
        logic [7:0]  t [4][4];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {m_sbox(tmp[23:16]), m_sbox(tmp[15:8]), m_sbox(tmp[7:0]), m_sbox(tmp[31:24])}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = m_sbox(s[r][(c+r)%4]);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (rnd < 10)
                        s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03)
                                  ^ t[(r+2)%4][c] ^ t[(r+3)%4][c] ^ w[4*rnd+c][31-8*r -: 8];
                    else
                        s[r][c] = t[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        ct = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ct[127-8*(4*c+r) -: 8] = s[r][c];
        k10 = {w[40], w[41], w[42], w[43]};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b0;
        bus_p.dat_in = VEC_PT[0];
        bus_p.key    = VEC_KEY[0];
        @(posedge clk); #1;
        total++;
        if (bus_p.dat_out !== 128'h0) begin
            bad++;
            $display("FAIL reset_dat_out got=%h want=0", bus_p.dat_out);
        end
        total++;
        if (bus_p.inv_key !== 128'h0) begin
            bad++;
            $display("FAIL reset_inv_key got=%h want=0", bus_p.inv_key);
        end
    endtask

    task automatic test_comb_vectors();
        for (int v = 0; v < 5; v++) begin
            bus_c.dat_in = VEC_PT[v];
            bus_c.key    = VEC_KEY[v];
            #1;
            total++;
            if (bus_c.dat_out !== VEC_CT[v]) begin
                bad++;
                $display("FAIL comb_ct[%0d] got=%h want=%h", v, bus_c.dat_out, VEC_CT[v]);
            end
            total++;
            if (bus_c.inv_key !== VEC_K10[v]) begin
                bad++;
                $display("FAIL comb_k10[%0d] got=%h want=%h", v, bus_c.inv_key, VEC_K10[v]);
            end
        end
    endtask

    task automatic test_single_round();
        logic [127:0] in_d [3];
        logic [127:0] in_k [3];
        logic [7:0]   in_rc [3];
        logic         in_skip [3];
        logic [127:0] ex_d [3];
        logic [127:0] ex_k [3];
        in_d[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; in_k[0] = VEC_KEY[0];
        in_rc[0] = 8'h01; in_skip[0] = 1'b0;
        ex_d[0] = 128'ha49c7ff2689f352b6b5bea43026a5049; ex_k[0] = 128'ha0fafe1788542cb123a339392a6c7605;
        in_d[1] = ex_d[0]; in_k[1] = ex_k[0]; in_rc[1] = 8'h02; in_skip[1] = 1'b0;
        ex_d[1] = 128'haa8f5f0361dde3ef82d24ad26832469a; ex_k[1] = 128'hf2c295f27a96b9435935807a7359f67f;
        in_d[2] = 128'heb40f21e592e38848ba113e71bc342d2; in_k[2] = 128'hac7766f319fadc2128d12941575c006e;
        in_rc[2] = 8'h36; in_skip[2] = 1'b1;
        ex_d[2] = VEC_CT[0]; ex_k[2] = VEC_K10[0];
        for (int i = 0; i < 3; i++) begin
            rnd_dat_in = in_d[i];
            rnd_key_in = in_k[i];
            rnd_rc     = in_rc[i];
            rnd_skip   = in_skip[i];
            #1;
            total++;
            if (rnd_dat_out !== ex_d[i]) begin
                bad++;
                $display("FAIL round_dat[%0d] got=%h want=%h", i, rnd_dat_out, ex_d[i]);
            end
            total++;
            if (rnd_key_out !== ex_k[i]) begin
                bad++;
                $display("FAIL round_key[%0d] got=%h want=%h", i, rnd_key_out, ex_k[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic [127:0] exp_ct [11];
        logic [127:0] exp_k10 [11];
        logic [127:0] c, k10;
        int           idx;
        for (int k = 0; k <= 10; k++) begin
            model_enc(VEC_PT[0] + 128'(k), VEC_KEY[0] + 128'(k), c, k10);
            exp_ct[k]  = c;
            exp_k10[k] = k10;
        end
        for (int e = 0; e < 21; e++) begin
            @(negedge clk);
            clr = 1'b1;
            idx = (e > 10) ? 10 : e;
            bus_p.dat_in = VEC_PT[0] + 128'(idx);
            bus_p.key    = VEC_KEY[0] + 128'(idx);
            @(posedge clk); #1;
            if (e >= 9) begin
                idx = (e - 9 > 10) ? 10 : e - 9;
                total++;
                if (bus_p.dat_out !== exp_ct[idx]) begin
                    bad++;
                    $display("FAIL stream_ct edge=%0d got=%h want=%h", e, bus_p.dat_out, exp_ct[idx]);
                end
                total++;
                if (bus_p.inv_key !== exp_k10[idx]) begin
                    bad++;
                    $display("FAIL stream_k10 edge=%0d got=%h want=%h", e, bus_p.inv_key, exp_k10[idx]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            bus_p.dat_in = VEC_PT[3 + (e % 2)];
            bus_p.key    = VEC_KEY[0] ^ 128'(e);
            @(posedge clk);
        end
        // Valid-looking data is present on the reset edge; clr must win.
        @(negedge clk);
        clr = 1'b0;
        bus_p.dat_in = VEC_PT[0];
        bus_p.key    = VEC_KEY[0];
        @(posedge clk); #1;
        total++;
        if (bus_p.dat_out !== 128'h0) begin
            bad++;
            $display("FAIL midreset_dat_out got=%h want=0", bus_p.dat_out);
        end
        total++;
        if (bus_p.inv_key !== 128'h0) begin
            bad++;
            $display("FAIL midreset_inv_key got=%h want=0", bus_p.inv_key);
        end
        @(negedge clk);
        clr = 1'b1;
        bus_p.dat_in = VEC_PT[1];
        bus_p.key    = VEC_KEY[1];
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 9) begin
                total++;
                if (bus_p.dat_out === VEC_CT[0]) begin
                    bad++;
                    $display("FAIL clr_priority got=%h want=not %h", bus_p.dat_out, VEC_CT[0]);
                end
            end
        end
        total++;
        if (bus_p.dat_out !== VEC_CT[1]) begin
            bad++;
            $display("FAIL after_reset_ct got=%h want=%h", bus_p.dat_out, VEC_CT[1]);
        end
        total++;
        if (bus_p.inv_key !== VEC_K10[1]) begin
            bad++;
            $display("FAIL after_reset_k10 got=%h want=%h", bus_p.inv_key, VEC_K10[1]);
        end
    endtask

    initial begin
        clr          = 1'b0;
        bus_c.dat_in = '0;
        bus_c.key    = '0;
        bus_p.dat_in = '0;
        bus_p.key    = '0;
        rnd_dat_in   = '0;
        rnd_key_in   = '0;
        rnd_rc       = '0;
        rnd_skip     = 1'b0;
        test_reset();
        test_comb_vectors();
        test_single_round();
        test_stream();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_128_cipher.md
# aes_128_cipher

AES-128 encryption core (FIPS-197): one 128-bit block and one 128-bit key in, ciphertext out, plus the final (round-10) round key. That key is the starting key for the companion decipher core. The core is built from ten chained round stages with on-the-fly key expansion. The same RTL is either fully combinational or a 10-stage pipeline, so it serves both as a reference model and as a streaming datapath.

## Interface
- LATENCY, default 10: 0 gives fully combinational operation. 10 gives one register stage per round, accepting one block per cycle. Any other value is an elaboration error.
- clk  in  1  single clock; rising edge.
- clr  in  1  reset, synchronous, active-low. Ignored when LATENCY=0.
- dat_in  in  128  plaintext; bits [127:120] are FIPS byte in0; the state is column-major (bytes 0-3 form column 0).
- key  in  128  cipher key, same byte order. Sampled together with dat_in.
- dat_out  out  128  ciphertext, same byte order.
- inv_key  out  128  round-10 key of the key that produced dat_out, time-aligned with dat_out.

## Operation
- Initial step: state = dat_in XOR key. This step is combinational and lies before stage 1.
- Rounds r = 1..10, each: SubBytes, ShiftRows, MixColumns (skipped in round 10), then XOR with round key r.
- Round key r comes from key r-1 via the standard expansion:
  - RotWord, SubWord, XOR rcon[r] into the first word, then a cascading XOR of the four words.
  - rcon = 01,02,04,08,10,20,40,80,1b,36.
- The round key travels alongside the state. No key schedule is stored and no precompute phase exists, so a new key is allowed every cycle.
- MixColumns uses GF(2^8) arithmetic with polynomial 0x11b; coefficients are 02,03,01,01 circulant.
- inv_key = round-10 key.

## Timing
- LATENCY=0: dat_out and inv_key are pure functions of dat_in and key; there is no clock dependence.
- LATENCY=10:
  - Each round registers its state output and key output on the rising clk edge.
  - The input sampled at edge N appears on dat_out and inv_key after edge N+9, i.e. following 10 rising edges counted from the sampling edge.
  - Throughput is one block per cycle. There is no handshake, valid or stall.
- Reset (clr=0 at a rising edge) clears all stage registers, including data and key, to 0.
  - dat_out and inv_key read 0 in the cycle after reset.
  - For the next 9 cycles, outputs are the rounds applied to the zeroed stage contents. They are not meaningful, and no valid flag marks this.
  - Reset mid-stream discards all in-flight blocks.
  - clr has priority over data capture.

## Structure
- Shared package aes_pkg:
  - 256-entry S-box constant.
  - rcon constant array indexed by round.
  - xtime function (mult-by-2 in GF(2^8)).
  - State and word typedefs (128-bit state, 32-bit word).
- Sub-module aes_round_128 performs one round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey and key evolution.
  - Inputs: dat_in, key_in, rconst[7:0], skip_mix_col.
  - Outputs: dat_out, key_out.
  - An optional output register pair is enabled per instance by the top parameter.
- Top: initial XOR, generate loop of 10 aes_round_128 instances (round 10 with skip_mix_col=1), and the inv_key tap.

## Test plan
- FIPS-197 App. B, LATENCY=0.
  - Stimulus: dat_in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: dat_out=3925841d02dc09fbdc118597196a0b32, inv_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Single round check, same vector: state after round 1 = a49c7ff2689f352b6b5bea43026a5049, round-1 key = a0fafe1788542cb123a339392a6c7605. Feeding these into aes_round_128 with rconst=02 gives state aa8f5f0361dde3ef82d24ad26832469a and key f2c295f27a96b9435935807a7359f67f.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. The all-zero key and plaintext -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
- LATENCY=10 stream:
  - Stimulus: apply the App. B vector, then increment both plain and key by 1 each cycle for 10 cycles, then hold.
  - Required: output k, appearing 10 edges after its input was sampled, equals the LATENCY=0 result for input k; inv_key matches that input's round-10 key.
- Reset:
  - clr=0 for one edge mid-stream gives dat_out=0 and inv_key=0 in the following cycle.
  - Fresh inputs applied after reset are correct 10 edges later.
